// File: rtl/maze_pkg.sv
// Shared constants and types for the maze viewport controller: opcodes, FSM
// states, default screen geometry and the arithmetic width used for view math.
package maze_pkg;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int ZOOM_MAX_DEF = 5;

  // Wide enough that screen sizes, maze sizes and +/-1 steps never wrap.
  localparam int CW = 12;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_LEFT     = 3'd1,
    OP_RIGHT    = 3'd2,
    OP_UP       = 3'd3,
    OP_DOWN     = 3'd4,
    OP_ZOOM_IN  = 3'd5,
    OP_ZOOM_OUT = 3'd6,
    OP_CENTER   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_CALC,
    S_COMMIT
  } state_e;

  // Number of whole tiles visible along one screen axis at a given tile shift.
  function automatic logic [CW-1:0] vis_tiles(input int screen, input logic [7:0] zoom);
    logic [CW-1:0] s;
    s = CW'(screen);
    return s >> zoom;
  endfunction

endpackage

// File: rtl/maze_view_clamp.sv
// Combinational viewport limiter: derives the largest legal origin for the
// current zoom and maze size, and clamps candidate origin coordinates to it.
module maze_view_clamp
  import maze_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic [7:0]    zoom,
  input  logic [6:0]    maze_width,
  input  logic [6:0]    maze_height,
  input  logic [CW-1:0] cand_x,
  input  logic [CW-1:0] cand_y,
  output logic [6:0]    x,
  output logic [6:0]    y
);

  logic [CW-1:0] vis_w, vis_h;
  logic [CW-1:0] mw, mh;
  logic [CW-1:0] max_x, max_y;

  always_comb begin
    vis_w = vis_tiles(SCREEN_W, zoom);
    vis_h = vis_tiles(SCREEN_H, zoom);
    mw    = CW'(maze_width);
    mh    = CW'(maze_height);
    // A maze narrower than the screen pins the origin to tile 0.
    max_x = (mw > vis_w) ? mw - vis_w : '0;
    max_y = (mh > vis_h) ? mh - vis_h : '0;
    x     = (cand_x > max_x) ? max_x[6:0] : cand_x[6:0];
    y     = (cand_y > max_y) ? max_y[6:0] : cand_y[6:0];
  end

endmodule

// File: rtl/maze_view_ctrl.sv
// Maze viewport controller: accepts pan/zoom/center commands and applies them
// only on a vsync rising edge, so the visible view changes during retrace only.
module maze_view_ctrl
  import maze_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int ZOOM_MAX = ZOOM_MAX_DEF,
  parameter int ZOOM_RST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic [6:0] maze_width,
  input  logic [6:0] maze_height,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [6:0] cmd_x,
  input  logic [6:0] cmd_y,
  output logic [6:0] x_coord,
  output logic [6:0] y_coord,
  output logic [7:0] tile_width,
  output logic [7:0] tile_height,
  output logic       update_pulse,
  output logic       busy
);

  state_e        state, state_n;
  logic          vsync_q, vsync_edge, accept;
  op_e           op_q;
  logic [6:0]    cx_q, cy_q;
  logic [7:0]    zoom_q, zoom_n;
  logic [CW-1:0] cand_x, cand_y, half_w, half_h;
  logic [6:0]    clamp_x, clamp_y;

  assign vsync_edge   = vsync & ~vsync_q;
  // Gated by reset so the handshake is closed while the block is held in reset.
  assign cmd_ready    = (state == S_IDLE) & reset;
  assign accept       = cmd_valid & cmd_ready;
  assign busy         = (state != S_IDLE);
  assign update_pulse = (state == S_COMMIT);
  assign tile_width   = zoom_q;
  assign tile_height  = zoom_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (accept)          state_n = vsync_edge ? S_CALC : S_PEND;
        else if (vsync_edge) state_n = S_CALC;
      end
      S_PEND:   if (vsync_edge) state_n = S_CALC;
      S_CALC:   state_n = S_COMMIT;
      S_COMMIT: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_comb begin
    zoom_n = zoom_q;
    cand_x = CW'(x_coord);
    cand_y = CW'(y_coord);
    half_w = vis_tiles(SCREEN_W, zoom_q) >> 1;
    half_h = vis_tiles(SCREEN_H, zoom_q) >> 1;
    unique case (op_q)
      OP_LEFT:     if (x_coord != '0) cand_x = CW'(x_coord) - CW'(1);
      OP_RIGHT:    cand_x = CW'(x_coord) + CW'(1);
      OP_UP:       if (y_coord != '0) cand_y = CW'(y_coord) - CW'(1);
      OP_DOWN:     cand_y = CW'(y_coord) + CW'(1);
      OP_ZOOM_IN:  if (zoom_q < 8'(ZOOM_MAX)) zoom_n = zoom_q + 8'd1;
      OP_ZOOM_OUT: if (zoom_q != '0) zoom_n = zoom_q - 8'd1;
      OP_CENTER: begin
        cand_x = (CW'(cx_q) > half_w) ? CW'(cx_q) - half_w : '0;
        cand_y = (CW'(cy_q) > half_h) ? CW'(cy_q) - half_h : '0;
      end
      default: ;
    endcase
  end

  // Limits are taken at the post-op zoom so zoom changes re-clamp the origin.
  maze_view_clamp #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_clamp (
    .zoom        (zoom_n),
    .maze_width  (maze_width),
    .maze_height (maze_height),
    .cand_x      (cand_x),
    .cand_y      (cand_y),
    .x           (clamp_x),
    .y           (clamp_y)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vsync_q <= 1'b0;
      op_q    <= OP_NOP;
      cx_q    <= '0;
      cy_q    <= '0;
      x_coord <= '0;
      y_coord <= '0;
      zoom_q  <= 8'(ZOOM_RST);
    end else begin
      vsync_q <= vsync;
      if (accept) begin
        op_q <= op_e'(cmd_op);
        cx_q <= cmd_x;
        cy_q <= cmd_y;
      end else if (state == S_IDLE && vsync_edge) begin
        op_q <= OP_NOP;
      end
      // Loaded at the end of CALC, so new values first appear in COMMIT.
      if (state == S_CALC) begin
        x_coord <= clamp_x;
        y_coord <= clamp_y;
        zoom_q  <= zoom_n;
      end
    end
  end

endmodule

// File: tb/tb_maze_view_ctrl.sv
// Self-checking bench for maze_view_ctrl: directed scenarios followed by random
// commands, compared against a plain-arithmetic model of the viewport rules.
module tb_maze_view_ctrl;

  logic       clk = 1'b0;
  logic       reset, vsync, cmd_valid, cmd_ready;
  logic [6:0] maze_width, maze_height, cmd_x, cmd_y, x_coord, y_coord;
  logic [2:0] cmd_op;
  logic [7:0] tile_width, tile_height;
  logic       update_pulse, busy;

  int n_cmp = 0;
  int n_err = 0;
  int m_x, m_y, m_z, e_x, e_y, e_z;
  int mw, mh;

  always #5 clk = ~clk;

  maze_view_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .vsync        (vsync),
    .maze_width   (maze_width),
    .maze_height  (maze_height),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_x        (cmd_x),
    .cmd_y        (cmd_y),
    .x_coord      (x_coord),
    .y_coord      (y_coord),
    .tile_width   (tile_width),
    .tile_height  (tile_height),
    .update_pulse (update_pulse),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: apply one op to the current view (m_*) and write the result to e_*.
  function automatic void model_apply(input int op, input int cx, input int cy);
    int x, y, z, vw, vh, mx, my;
    x = m_x; y = m_y; z = m_z;
    case (op)
      1: if (x > 0) x = x - 1;
      2: x = x + 1;
      3: if (y > 0) y = y - 1;
      4: y = y + 1;
      5: if (z < 5) z = z + 1;
      6: if (z > 0) z = z - 1;
      7: begin
        x = cx - (640 >> z) / 2;
        y = cy - (480 >> z) / 2;
        if (x < 0) x = 0;
        if (y < 0) y = 0;
      end
      default: ;
    endcase
    vw = 640 >> z;
    vh = 480 >> z;
    mx = (mw > vw) ? mw - vw : 0;
    my = (mh > vh) ? mh - vh : 0;
    e_x = (x > mx) ? mx : x;
    e_y = (y > my) ? my : y;
    e_z = z;
  endfunction

  // Called on the negedge where vsync has just risen (start=0) or one later.
  task automatic wait_commit(input int start);
    int cyc;
    cyc = start;
    while (update_pulse !== 1'b1 && cyc < 10) begin
      check("hold_x", 32'(x_coord), m_x);
      check("hold_y", 32'(y_coord), m_y);
      @(negedge clk);
      cyc++;
    end
    check("commit_latency", cyc, 2);
    if (update_pulse === 1'b1) begin
      check("x_coord", 32'(x_coord), e_x);
      check("y_coord", 32'(y_coord), e_y);
      check("tile_width", 32'(tile_width), e_z);
      check("tile_height", 32'(tile_height), e_z);
    end
    m_x = e_x; m_y = e_y; m_z = e_z;
    @(negedge clk);
    check("pulse_width", 32'(update_pulse), 0);
    check("busy_after", 32'(busy), 0);
    vsync = 1'b0;
  endtask

  task automatic run_cmd(input int op, input int cx, input int cy, input bit coincide);
    model_apply(op, cx, cy);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_x     = 7'(cx);
    cmd_y     = 7'(cy);
    if (coincide) vsync = 1'b1;
    check("cmd_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (coincide) begin
      wait_commit(1);
    end else begin
      check("busy_pend", 32'(busy), 1);
      check("pend_no_pulse", 32'(update_pulse), 0);
      vsync = 1'b1;
      wait_commit(0);
    end
  endtask

  task automatic idle_vsync();
    model_apply(0, 0, 0);
    @(negedge clk);
    vsync = 1'b1;
    wait_commit(0);
  endtask

  initial begin
    reset = 1'b0; vsync = 1'b0; cmd_valid = 1'b0;
    cmd_op = '0; cmd_x = '0; cmd_y = '0;
    mw = 64; mh = 64;
    maze_width = 7'd64; maze_height = 7'd64;
    m_x = 0; m_y = 0; m_z = 4;

    repeat (3) @(negedge clk);
    check("ready_in_reset", 32'(cmd_ready), 0);
    reset = 1'b1;
    #1;
    check("rst_x", 32'(x_coord), 0);
    check("rst_y", 32'(y_coord), 0);
    check("rst_tile", 32'(tile_width), 4);
    check("rst_ready", 32'(cmd_ready), 1);
    check("rst_pulse", 32'(update_pulse), 0);
    check("rst_busy", 32'(busy), 0);

    for (int i = 0; i < 25; i++) run_cmd(2, 0, 0, 1'b0);
    check("right_sat", 32'(x_coord), 24);
    for (int i = 0; i < 40; i++) run_cmd(4, 0, 0, 1'b0);
    check("down_sat", 32'(y_coord), 34);

    mw = 30; mh = 20;
    maze_width = 7'd30; maze_height = 7'd20;
    idle_vsync();
    check("resize_x", 32'(x_coord), 0);
    check("resize_y", 32'(y_coord), 0);

    mw = 64; mh = 64;
    maze_width = 7'd64; maze_height = 7'd64;
    run_cmd(7, 32, 32, 1'b0);
    check("center_x", 32'(x_coord), 12);
    check("center_y", 32'(y_coord), 17);

    // Reset while a RIGHT is waiting for vsync: it must be dropped.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_busy", 32'(busy), 1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_ready_low", 32'(cmd_ready), 0);
      check("mid_no_pulse", 32'(update_pulse), 0);
    end
    reset = 1'b1;
    #1;
    check("mid_ready", 32'(cmd_ready), 1);
    check("mid_x", 32'(x_coord), 0);
    check("mid_tile", 32'(tile_width), 4);
    m_x = 0; m_y = 0; m_z = 4;
    idle_vsync();
    check("mid_discard_x", 32'(x_coord), 0);

    for (int i = 0; i < 6; i++) run_cmd(6, 0, 0, 1'b0);
    check("zoom_out_sat", 32'(tile_width), 0);
    for (int i = 0; i < 7; i++) run_cmd(5, 0, 0, 1'b0);
    check("zoom_in_sat", 32'(tile_height), 5);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        mw = int'($urandom_range(1, 64));
        mh = int'($urandom_range(1, 64));
        maze_width  = 7'(mw);
        maze_height = 7'(mh);
      end
      if ($urandom_range(0, 4) == 0)
        idle_vsync();
      else
        run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 127)),
                int'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/maze_view_ctrl.md
MAZE_VIEW_CTRL -- requirements
Module: maze_view_ctrl

Interface
REQ-001 Parameter SCREEN_W, default 640: visible pixel columns.
REQ-002 Parameter SCREEN_H, default 480: visible pixel rows.
REQ-003 Parameter ZOOM_MAX, default 5: largest tile shift (tile = 2^shift pixels).
REQ-004 Parameter ZOOM_RST, default 4: tile shift after reset.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 vsync  input  1  raster vertical sync, high during vertical retrace.
REQ-008 maze_width, maze_height  input  7 each  maze size in tiles, 1..64.
REQ-009 cmd_valid  input  1  command request.
REQ-010 cmd_ready  output  1  controller can accept a command.
REQ-011 cmd_op  input  3  0 NOP, 1 LEFT, 2 RIGHT, 3 UP, 4 DOWN, 5 ZOOM_IN, 6 ZOOM_OUT, 7 CENTER.
REQ-012 cmd_x, cmd_y  input  7 each  target tile for CENTER.
REQ-013 x_coord, y_coord  output  7 each  viewport origin tile.
REQ-014 tile_width, tile_height  output  8 each  tile shift amount, always equal.
REQ-015 update_pulse  output  1  one-cycle strobe when new view values are committed.
REQ-016 busy  output  1  command pending or in computation.

Function
REQ-017 The FSM SHALL have states IDLE, PEND, CALC, COMMIT.
REQ-018 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on cmd_valid&&cmd_ready and latched (op, x, y).
REQ-019 After acceptance, IDLE SHALL go to PEND; busy SHALL be 1 in PEND, CALC and COMMIT.
REQ-020 A vsync rising edge SHALL be detected using one registered copy of vsync. In PEND, a detected edge SHALL move the FSM to CALC.
REQ-021 CALC SHALL take one cycle and compute candidate values. COMMIT SHALL register the outputs, assert update_pulse for that cycle, and return to IDLE.
REQ-022 In IDLE, a detected vsync edge with no command accepted that cycle SHALL run CALC/COMMIT with an implicit NOP, which re-clamps to the current maze size.
REQ-023 When cmd_valid and a vsync edge coincide in IDLE, the command SHALL be accepted and the edge SHALL be consumed by that command, going directly to CALC.
REQ-024 Visible tiles: vis_w = SCREEN_W >> zoom, vis_h = SCREEN_H >> zoom. Limits: max_x = maze_width-vis_w if maze_width > vis_w, else 0; max_y is defined the same way.
REQ-025 LEFT/UP SHALL decrement the coordinate by 1, saturating at 0. RIGHT/DOWN SHALL increment it by 1, saturating at max_x/max_y.
REQ-026 ZOOM_IN SHALL increment zoom, saturating at ZOOM_MAX. ZOOM_OUT SHALL decrement zoom, saturating at 0. Limits SHALL be recomputed with the new zoom.
REQ-027 CENTER SHALL set x = cmd_x - vis_w/2 and y = cmd_y - vis_h/2, each floored at 0.
REQ-028 After every op, including NOP, x_coord and y_coord SHALL be clamped to max_x and max_y.
REQ-029 All intermediate arithmetic SHALL use at least 11 bits so no overflow or underflow occurs before saturation.
REQ-030 Outputs SHALL change only in COMMIT, which guarantees updates happen only during vertical retrace.

Reset
REQ-031 On reset low: FSM to IDLE; x_coord=0, y_coord=0; tile_width=tile_height=ZOOM_RST; update_pulse=0; busy=0; registered vsync=0; latched command cleared.
REQ-032 cmd_ready SHALL be 0 while reset is low, and 1 in the first cycle after release.
REQ-033 Reset asserted mid-operation SHALL discard any pending command without committing it.

Structure
REQ-034 The opcode constants, SCREEN_W/SCREEN_H defaults and ZOOM_MAX SHALL live in shared package maze_pkg.
REQ-035 Limit computation and clamping SHALL be a combinational sub-module maze_view_clamp (inputs: zoom, maze size, candidate x/y; outputs: clamped x/y).

Verification
REQ-036 Release reset -> x=0, y=0, tile=4, cmd_ready=1, update_pulse=0.
REQ-037 64x64 maze, zoom 4 (40x30 visible), 25 RIGHT commands, each followed by vsync -> x saturates at 24; DOWN x40 -> y saturates at 34.
REQ-038 ZOOM_OUT x6 from zoom 4 -> tile=0 and stays 0. Then ZOOM_IN x7 -> tile=5 and stays 5.
REQ-039 CENTER(32,32) at zoom 4 -> outputs unchanged until the vsync rise; 2 cycles after the detected edge, x=12, y=17, with update_pulse high for 1 cycle.
REQ-040 RIGHT accepted, then reset pulsed low before vsync -> x=0, no update_pulse, cmd_ready=1 after release.
REQ-041 x=24, y=34 at zoom 4, maze resized to 30x20, no command issued -> after next vsync edge, x=0, y=0 via implicit NOP.
